rvv_backend_dispatch_raw_scoreboard: RTL
========================================

// Module: rvv_backend_dispatch_raw_scoreboard
// PURPOSE
//  Registered RAW-hazard scoreboard for the dispatch stage; successor of the per-pair uop/uop comparator.
//  Tracks outstanding VRF writes per architectural vreg with counters, not by pairwise compare with in-flight uops.
//  Per cycle: checks up to DISPATCH_NUM in-order candidate uops, flags RAW waits, grants an in-order dispatch prefix.
//  Sits between the uop queue and the RS/ROB allocation in rvv_backend_dispatch.
// PARAMETERS
//  DISPATCH_NUM  2  candidate uops checked/dispatched per cycle (1..4)
//  WB_NUM        4  VRF writeback ports that retire pending writes
//  CNT_W         3  width of each per-vreg pending counter (max outstanding = 2**CNT_W-1)
// PORTS
//  clk           in   1                    clock
//  rst_n         in   1                    async active-low reset
//  flush         in   1                    pipeline flush (trap/redirect); clears scoreboard
//  uop_valid     in   DISPATCH_NUM         candidate uop present; slot 0 is oldest
//  suc_uop       in   DISPATCH_NUM x SUC_UOP_RAW_t   source fields: vs1/vs2/vd index, *_valid, vm
//  dst_uop       in   DISPATCH_NUM x DST_UOP_SB_t    dest fields: w_valid, w_index[4:0], w_type
//  uop_ready     out  DISPATCH_NUM         uop dispatches this cycle (valid & ready)
//  raw_wait      out  DISPATCH_NUM x RAW_UOP_UOP_t   vs1/vs2/vd/v0 wait flags, debug/perf
//  wb_valid      in   WB_NUM               a VRF write of an earlier-dispatched uop completes
//  wb_index      in   WB_NUM x 5           vreg written
//  pend_vec      out  32                   bit r set when pend_cnt[r]!=0 (registered view)
//  sb_busy       out  1                    |pend_vec
// BEHAVIOUR
//  - State: pend_cnt[0..31], CNT_W bits each; reset and flush value 0. Outputs at reset: uop_ready=0,
//    raw_wait=0, pend_vec=0, sb_busy=0.
//  - Write tracked iff dst_uop.w_valid & (w_type==VRF); XRF/none dsts never touch counters.
//  - Source wait for slot i, field f in {vs1,vs2,vd(vs3_valid),v0(~vm, index V0_INDEX)}:
//    f_valid & (pend_cnt[idx]!=0 | any older slot j<i with uop_valid[j] & tracked write to idx).
//  - Capacity stall slot i: tracked write & pend_cnt[w_index] > (2**CNT_W-1) - DISPATCH_NUM.
//  - uop_ready[i] = uop_valid[i] & ~|raw_wait[i] & ~cap_stall[i] & ~flush & (i==0 | uop_ready[i-1]).
//    Strict in-order prefix; a stalled slot blocks all younger slots. Combinational, 0-cycle latency.
//  - Update (posedge): pend_cnt[r] <= pend_cnt[r] + inc[r] - dec[r]; inc[r] = # ready slots writing r,
//    dec[r] = # wb ports with wb_valid & wb_index==r. Same-cycle inc and dec on one reg net out exactly.
//  - Underflow (dec > cnt+inc) is a protocol error: counter saturates at 0; SVA assertion fires.
//  - Overflow impossible by capacity stall; SVA asserts cnt+inc-dec <= 2**CNT_W-1.
//  - flush has priority: all counters 0 next cycle; wb in the flush cycle ignored; uop_ready=0 that cycle.
//  - Async reset mid-operation: counters clear immediately; first post-reset cycle behaves as empty.
//  - pend_vec/sb_busy derive from registered counters (reflect state before this cycle's update).
// CONFIGURATION
//  RAW_BYPASS_EN defined: a source wait on pend_cnt[idx] is suppressed when pend_cnt[idx]==dec[idx]
//    (every outstanding write to idx completes this cycle, operand via writeback bypass). Intra-group
//    older-slot hits still wait.
//  RAW_BYPASS_EN undefined: source waits until pend_cnt[idx] reads 0, one cycle after the last wb.
// STRUCTURE
//  - Shared header rvv_backend_dispatch.svh: SUC_UOP_RAW_t, RAW_UOP_UOP_t (reused), new DST_UOP_SB_t,
//    V0_INDEX, NUM_VREG=32, w_type enum (VRF/XRF).
//  - Sub-module rvv_backend_dispatch_sb_cnt: one per vreg (generate x32). Inputs inc/dec counts + flush;
//    outputs cnt and nonzero flag.
//  - Top: source/older-slot compare, ready prefix chain, inc/dec popcount per vreg, assertions.
// TESTING
//  1 reset, slot0 writes v4, slot1 reads vs2=v4 -> uop_ready=01, raw_wait[1].vs2_wait=1; next cycle pend_cnt[4]=1.
//  2 pend_cnt[4]=1, wb_valid[0] index 4, slot0 reads v4 -> no bypass: ready=0 that cycle, ready=1 next;
//    RAW_BYPASS_EN: ready=1 same cycle.
//  3 Same cycle: slot0 writes v8, wb port2 retires v8, pend_cnt[8]=1 -> pend_cnt[8] stays 1.
//  4 CNT_W=3, DISPATCH_NUM=2: dispatch writes to v1 until pend_cnt[1]=6 -> further v1 writers cap-stall;
//    one wb to v1 -> writer dispatches.
//  5 vm=0 uop with pend_cnt[0]=2 -> v0_wait=1; same uop with vm=1 -> dispatches.
//  6 pend_cnt nonzero on 5 regs, assert flush -> uop_ready=0; next cycle pend_vec=0, sb_busy=0.
//    rst_n low mid-burst gives the same result asynchronously.

Source files
------------

// File: rtl/rvv_backend_dispatch_raw_scoreboard_pkg.sv
// Shared types for the dispatch RAW scoreboard: source/destination views of a
// uop, per-slot wait flags and the destination register-file encoding.
package rvv_backend_dispatch_raw_scoreboard_pkg;

  localparam int         NUM_VREG = 32;
  localparam logic [4:0] V0_INDEX = 5'd0;

  typedef enum logic {
    VRF = 1'b0,
    XRF = 1'b1
  } w_type_e;

  typedef struct packed {
    logic [4:0] vs1_index;
    logic       vs1_valid;
    logic [4:0] vs2_index;
    logic       vs2_valid;
    logic [4:0] vd_index;
    logic       vs3_valid;
    logic       vm;
  } SUC_UOP_RAW_t;

  typedef struct packed {
    logic vs1_wait;
    logic vs2_wait;
    logic vd_wait;
    logic v0_wait;
  } RAW_UOP_UOP_t;

  typedef struct packed {
    logic       w_valid;
    logic [4:0] w_index;
    w_type_e    w_type;
  } DST_UOP_SB_t;

  // Only vector-register writes occupy a scoreboard counter.
  function automatic logic is_tracked(input DST_UOP_SB_t d);
    return d.w_valid & (d.w_type == VRF);
  endfunction

endpackage

// File: rtl/rvv_backend_dispatch_raw_scoreboard_chk.sv
// Protocol checker for one scoreboard counter: a writeback must never retire
// more writes than are outstanding, and the counter must never wrap.
module rvv_backend_dispatch_raw_scoreboard_chk #(
  parameter int CNT_W = 3,
  parameter int INC_W = 2,
  parameter int DEC_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic             flush,
  input logic [CNT_W-1:0] cnt,
  input logic [INC_W-1:0] inc,
  input logic [DEC_W-1:0] dec
);
  localparam int SUM_W   = CNT_W + INC_W + DEC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [SUM_W-1:0] sum_s;
  logic [SUM_W-1:0] dec_s;

  assign sum_s = SUM_W'(cnt) + SUM_W'(inc);
  assign dec_s = SUM_W'(dec);

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !flush |-> (dec_s <= sum_s));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (!flush && (dec_s <= sum_s)) |-> ((sum_s - dec_s) <= SUM_W'(CNT_MAX)));

endmodule

// File: rtl/rvv_backend_dispatch_raw_scoreboard_sb_cnt.sv
// Pending-write counter for one architectural vreg. Adds the writes dispatched
// this cycle, subtracts the writebacks completing this cycle; flush clears it.
module rvv_backend_dispatch_raw_scoreboard_sb_cnt #(
  parameter int CNT_W = 3,
  parameter int INC_W = 2,
  parameter int DEC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [INC_W-1:0] inc,
  input  logic [DEC_W-1:0] dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero
);
  localparam int SUM_W = CNT_W + INC_W + DEC_W;

  logic [SUM_W-1:0] sum_s;
  logic [SUM_W-1:0] dec_ext_s;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Net the increment and decrement; an excess decrement saturates at zero.
  always_comb begin
    sum_s     = SUM_W'(cnt_q) + SUM_W'(inc);
    dec_ext_s = SUM_W'(dec);
    if (flush) begin
      cnt_d = '0;
    end else if (dec_ext_s > sum_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = CNT_W'(sum_s - dec_ext_s);
    end
  end

  // Counter register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign nonzero = |cnt_q;

  rvv_backend_dispatch_raw_scoreboard_chk #(
    .CNT_W(CNT_W),
    .INC_W(INC_W),
    .DEC_W(DEC_W)
  ) u_chk (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .cnt  (cnt_q),
    .inc  (inc),
    .dec  (dec)
  );

endmodule

// File: rtl/rvv_backend_dispatch_raw_scoreboard.sv
// Dispatch-stage RAW scoreboard. One pending-write counter per vreg; each
// cycle up to DISPATCH_NUM in-order candidates are checked against the
// counters and against older candidates in the same group, and a strict
// in-order prefix is granted.
// Optional feature macro: RAW_BYPASS_EN -- a source whose outstanding writes
// all complete this cycle does not wait (operand comes from the writeback
// bypass). Without it a source waits until its counter reads zero.
module rvv_backend_dispatch_raw_scoreboard
  import rvv_backend_dispatch_raw_scoreboard_pkg::*;
#(
  parameter int DISPATCH_NUM = 2,
  parameter int WB_NUM       = 4,
  parameter int CNT_W        = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [DISPATCH_NUM-1:0] uop_valid,
  input  SUC_UOP_RAW_t            suc_uop   [DISPATCH_NUM],
  input  DST_UOP_SB_t             dst_uop   [DISPATCH_NUM],
  output logic [DISPATCH_NUM-1:0] uop_ready,
  output RAW_UOP_UOP_t            raw_wait  [DISPATCH_NUM],
  input  logic [WB_NUM-1:0]       wb_valid,
  input  logic [4:0]              wb_index  [WB_NUM],
  output logic [31:0]             pend_vec,
  output logic                    sb_busy
);
  localparam int INC_W   = $clog2(DISPATCH_NUM + 1);
  localparam int DEC_W   = $clog2(WB_NUM + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  // A writer is held back once its counter could not absorb a full group.
  localparam logic [CNT_W-1:0] CAP_LIM = CNT_W'(CNT_MAX - DISPATCH_NUM);

  logic [CNT_W-1:0]        pend_cnt_s [NUM_VREG];
  logic [NUM_VREG-1:0]     pend_nz_s;
  logic [NUM_VREG-1:0]     src_pend_s;
  logic [INC_W-1:0]        inc_s      [NUM_VREG];
  logic [DEC_W-1:0]        dec_s      [NUM_VREG];
  logic [DISPATCH_NUM-1:0] tracked_s;
  logic [DISPATCH_NUM-1:0] cap_s;
  logic [DISPATCH_NUM-1:0] ready_s;
  RAW_UOP_UOP_t            wait_s     [DISPATCH_NUM];

  // Slots whose destination is a tracked vector-register write.
  always_comb begin
    for (int i = 0; i < DISPATCH_NUM; i++) begin
      tracked_s[i] = is_tracked(dst_uop[i]);
    end
  end

  // Count completing writebacks per vreg and mark vregs that still hold a hazard.
  always_comb begin
    for (int r = 0; r < NUM_VREG; r++) begin
      dec_s[r] = '0;
      for (int p = 0; p < WB_NUM; p++) begin
        dec_s[r] = dec_s[r] + DEC_W'(wb_valid[p] & (wb_index[p] == 5'(r)));
      end
`ifdef RAW_BYPASS_EN
      src_pend_s[r] = pend_nz_s[r] & (32'(pend_cnt_s[r]) != 32'(dec_s[r]));
`else
      src_pend_s[r] = pend_nz_s[r];
`endif
    end
  end

  // Per-slot source hazards, capacity stall and the in-order ready prefix.
  always_comb begin
    logic [4:0] idx [4];
    logic [3:0] vld;
    logic [3:0] hit;
    logic       chain;
    chain = rst_n & ~flush;
    for (int i = 0; i < DISPATCH_NUM; i++) begin
      idx[0] = suc_uop[i].vs1_index;
      idx[1] = suc_uop[i].vs2_index;
      idx[2] = suc_uop[i].vd_index;
      idx[3] = V0_INDEX;
      vld    = {~suc_uop[i].vm, suc_uop[i].vs3_valid, suc_uop[i].vs2_valid, suc_uop[i].vs1_valid};
      for (int f = 0; f < 4; f++) begin
        hit[f] = src_pend_s[idx[f]];
        for (int j = 0; j < DISPATCH_NUM; j++) begin
          hit[f] = hit[f] | ((j < i) & uop_valid[j] & tracked_s[j] &
                             (dst_uop[j].w_index == idx[f]));
        end
      end
      hit       = hit & vld & {4{rst_n}};
      wait_s[i] = '{vs1_wait: hit[0], vs2_wait: hit[1], vd_wait: hit[2], v0_wait: hit[3]};
      cap_s[i]  = tracked_s[i] & (pend_cnt_s[dst_uop[i].w_index] > CAP_LIM);
      chain     = chain & uop_valid[i] & ~(|hit) & ~cap_s[i];
      ready_s[i] = chain;
    end
  end

  // Number of dispatching slots adding a tracked write to each vreg.
  always_comb begin
    for (int r = 0; r < NUM_VREG; r++) begin
      inc_s[r] = '0;
      for (int i = 0; i < DISPATCH_NUM; i++) begin
        inc_s[r] = inc_s[r] + INC_W'(ready_s[i] & tracked_s[i] &
                                     (dst_uop[i].w_index == 5'(r)));
      end
    end
  end

  for (genvar r = 0; r < NUM_VREG; r++) begin : g_cnt
    rvv_backend_dispatch_raw_scoreboard_sb_cnt #(
      .CNT_W(CNT_W),
      .INC_W(INC_W),
      .DEC_W(DEC_W)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .inc    (inc_s[r]),
      .dec    (dec_s[r]),
      .cnt    (pend_cnt_s[r]),
      .nonzero(pend_nz_s[r])
    );
  end

  assign uop_ready = ready_s;
  assign raw_wait  = wait_s;
  assign pend_vec  = pend_nz_s;
  assign sb_busy   = |pend_nz_s;

endmodule
